// File: rtl/sdf_bf_stage.sv
// Radix-2 single-delay-feedback butterfly stage; drives and consumes an external LENGTH-deep delay line.
// Latency: first output (x[0]+x[LENGTH]) is registered LENGTH+1 cycles after x[0] is accepted.
// Backpressure: none; a missing sample mid-frame is zero-filled and flagged, and a sample arriving during flush is dropped and flagged.
// Build option: define SDF_BF_SAT_EN to saturate sum/diff to 18 bits; the default build wraps.
module sdf_bf_stage #(
  parameter int LENGTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [17:0] in_r,
  input  logic [17:0] in_i,
  input  logic [17:0] fb_in_r,
  input  logic [17:0] fb_in_i,
  output logic [17:0] fb_out_r,
  output logic [17:0] fb_out_i,
  output logic        out_valid,
  output logic [17:0] out_r,
  output logic [17:0] out_i,
  output logic        frame_err
);

  // Counter spans one full frame (2*LENGTH samples); LENGTH=1 still needs one bit.
  localparam int CW = (LENGTH > 1) ? $clog2(2 * LENGTH) : 1;
  localparam logic [CW-1:0] HALF   = CW'(LENGTH);
  localparam logic [CW-1:0] LAST_A = CW'(LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            primed_q, primed_d;
  logic [17:0]     out_r_q, out_r_d;
  logic [17:0]     out_i_q, out_i_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_err_q, frame_err_d;

  logic [17:0]     in_eff_r, in_eff_i;
  logic [17:0]     sum_r, sum_i, diff_r, diff_i;
  logic [17:0]     fb_r, fb_i;
  logic            phase_b;
  logic            flush_now;

`ifdef SDF_BF_SAT_EN
  // Clamp a 19-bit result into the 18-bit two's-complement range.
  function automatic logic [17:0] sat18(input logic [18:0] v);
    logic [17:0] res;
    if (v[18] != v[17]) begin
      res = v[18] ? 18'h20000 : 18'h1FFFF;
    end else begin
      res = v[17:0];
    end
    return res;
  endfunction
`endif

  // Butterfly arithmetic; a missing sample contributes zero.
  always_comb begin
    in_eff_r = in_valid ? in_r : 18'd0;
    in_eff_i = in_valid ? in_i : 18'd0;
`ifdef SDF_BF_SAT_EN
    sum_r  = sat18({fb_in_r[17], fb_in_r} + {in_eff_r[17], in_eff_r});
    sum_i  = sat18({fb_in_i[17], fb_in_i} + {in_eff_i[17], in_eff_i});
    diff_r = sat18({fb_in_r[17], fb_in_r} - {in_eff_r[17], in_eff_r});
    diff_i = sat18({fb_in_i[17], fb_in_i} - {in_eff_i[17], in_eff_i});
`else
    // Keeping the low 18 bits of the 19-bit result is plain 18-bit modular arithmetic.
    sum_r  = fb_in_r + in_eff_r;
    sum_i  = fb_in_i + in_eff_i;
    diff_r = fb_in_r - in_eff_r;
    diff_i = fb_in_i - in_eff_i;
`endif
  end

  // Phase decode; a RUN cycle at cnt=0 without a sample is the first flush cycle.
  always_comb begin
    phase_b   = (cnt_q >= HALF);
    flush_now = (state_q == ST_FLUSH) ||
                ((state_q == ST_RUN) && (cnt_q == '0) && !in_valid);
  end

  // Next-state, counter and output-register selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    fb_r        = 18'd0;
    fb_i        = 18'd0;

    if (flush_now) begin
      // Drain the stored differences; the delay line refills with zeros.
      out_r_d     = fb_in_r;
      out_i_d     = fb_in_i;
      out_valid_d = 1'b1;
      if ((state_q == ST_FLUSH) && in_valid) begin
        frame_err_d = 1'b1;
      end
      if (cnt_q == LAST_A) begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        primed_d = 1'b0;
      end else begin
        state_d = ST_FLUSH;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (in_valid) begin
            // Accept x[0] as a Phase A sample at cnt=0.
            fb_r        = in_r;
            fb_i        = in_i;
            out_r_d     = fb_in_r;
            out_i_d     = fb_in_i;
            out_valid_d = primed_q;
            cnt_d       = CW'(1);
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          // cnt=0 without a sample was taken as flush above, so a gap here is mid-frame.
          if (!in_valid) begin
            frame_err_d = 1'b1;
          end
          cnt_d = cnt_q + CW'(1);
          if (!phase_b) begin
            // Phase A: park the sample, emit the previous frame's differences.
            fb_r        = in_eff_r;
            fb_i        = in_eff_i;
            out_r_d     = fb_in_r;
            out_i_d     = fb_in_i;
            out_valid_d = primed_q;
          end else begin
            // Phase B: emit sums, park differences for the next half-frame.
            fb_r        = diff_r;
            fb_i        = diff_i;
            out_r_d     = sum_r;
            out_i_d     = sum_i;
            out_valid_d = 1'b1;
            primed_d    = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_r_q     <= 18'd0;
      out_i_q     <= 18'd0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Delay-line input is held at zero while reset is asserted.
  always_comb begin
    fb_out_r = rst_n ? fb_r : 18'd0;
    fb_out_i = rst_n ? fb_i : 18'd0;
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage at LENGTH = 2, 1 and 4, each with a modelled delay line.
// Inputs are driven 1 time unit after the rising edge; registered outputs are sampled there too.
// Expected values are hand-computed butterfly results for each vector.
module tb_sdf_bf_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [17:0] in_r;
  logic [17:0] in_i;

  logic [17:0] fbi_r_w [3];
  logic [17:0] fbi_i_w [3];
  logic [17:0] fbo_r_w [3];
  logic [17:0] fbo_i_w [3];
  logic        out_valid_w [3];
  logic [17:0] out_r_w [3];
  logic [17:0] out_i_w [3];
  logic        frame_err_w [3];

  logic [35:0] dl [3][4];

  int    n_checks;
  int    n_errors;
  int    sel;
  string tname;

`ifdef SDF_BF_SAT_EN
  localparam int WRAP_SUM  = 131071;
  localparam int WRAP_DIFF = -131072;
`else
  localparam int WRAP_SUM  = -131072;
  localparam int WRAP_DIFF = 131071;
`endif

  sdf_bf_stage #(.LENGTH(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .fb_in_r(fbi_r_w[0]), .fb_in_i(fbi_i_w[0]), .fb_out_r(fbo_r_w[0]), .fb_out_i(fbo_i_w[0]),
    .out_valid(out_valid_w[0]), .out_r(out_r_w[0]), .out_i(out_i_w[0]), .frame_err(frame_err_w[0])
  );

  sdf_bf_stage #(.LENGTH(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .fb_in_r(fbi_r_w[1]), .fb_in_i(fbi_i_w[1]), .fb_out_r(fbo_r_w[1]), .fb_out_i(fbo_i_w[1]),
    .out_valid(out_valid_w[1]), .out_r(out_r_w[1]), .out_i(out_i_w[1]), .frame_err(frame_err_w[1])
  );

  sdf_bf_stage #(.LENGTH(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .fb_in_r(fbi_r_w[2]), .fb_in_i(fbi_i_w[2]), .fb_out_r(fbo_r_w[2]), .fb_out_i(fbo_i_w[2]),
    .out_valid(out_valid_w[2]), .out_r(out_r_w[2]), .out_i(out_i_w[2]), .frame_err(frame_err_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay lines: shift every clock, taps at depth 2, 1 and 4.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      dl[k][0] <= {fbo_i_w[k], fbo_r_w[k]};
      for (int j = 1; j < 4; j++) begin
        dl[k][j] <= dl[k][j-1];
      end
    end
  end

  assign fbi_r_w[0] = dl[0][1][17:0];
  assign fbi_i_w[0] = dl[0][1][35:18];
  assign fbi_r_w[1] = dl[1][0][17:0];
  assign fbi_i_w[1] = dl[1][0][35:18];
  assign fbi_r_w[2] = dl[2][3][17:0];
  assign fbi_i_w[2] = dl[2][3][35:18];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s %s: got %0d, expected %0d", tname, tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input cycle, then check what the DUT registered at that edge.
  task automatic cyc(input bit v, input int r, input int i,
                     input int ev, input int er, input int ei, input int ee);
    logic [17:0] r18;
    logic [17:0] i18;
    r18 = r[17:0];
    i18 = i[17:0];
    in_valid = v;
    in_r     = r18;
    in_i     = i18;
    tick();
    chk("out_valid", int'(out_valid_w[sel]), ev);
    if (ev != 0) begin
      chk("out_r", int'($signed(out_r_w[sel])), er);
      chk("out_i", int'($signed(out_i_w[sel])), ei);
    end
    chk("frame_err", int'(frame_err_w[sel]), ee);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_r     = '0;
    in_i     = '0;
    repeat (6) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sel      = 0;
    tname    = "reset";
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", int'(out_valid_w[k]), 0);
      chk("rst_out_r", int'($signed(out_r_w[k])), 0);
      chk("rst_frame_err", int'(frame_err_w[k]), 0);
    end

    // LENGTH=2: reset after three samples, with a gap pending in the reset cycle.
    tname = "midreset";
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 1, 4, 0, 0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_r     = 18'd4;
    #1;
    chk("fb_out_r_in_reset", int'($signed(fbo_r_w[0])), 0);
    tick();
    chk("out_valid", int'(out_valid_w[0]), 0);
    chk("out_r", int'($signed(out_r_w[0])), 0);
    chk("out_i", int'($signed(out_i_w[0])), 0);
    chk("frame_err", int'(frame_err_w[0]), 0);
    rst_n = 1'b1;
    in_r  = '0;
    #1;
    chk("fb_out_r_idle", int'($signed(fbo_r_w[0])), 0);

    // LENGTH=2 single frame 1,2,3,4.
    tname = "single";
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 1, 4, 0, 0);
    cyc(1, 4, 0, 1, 6, 0, 0);
    cyc(0, 0, 0, 1, -2, 0, 0);
    cyc(0, 0, 0, 1, -2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // LENGTH=2 back-to-back frames with no bubble.
    tname = "b2b";
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 1, 4, 0, 0);
    cyc(1, 4, 0, 1, 6, 0, 0);
    cyc(1, 10, 0, 1, -2, 0, 0);
    cyc(1, 20, 0, 1, -2, 0, 0);
    cyc(1, 30, 0, 1, 40, 0, 0);
    cyc(1, 40, 0, 1, 60, 0, 0);
    cyc(0, 0, 0, 1, -20, 0, 0);
    cyc(0, 0, 0, 1, -20, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // LENGTH=1 overflow behaviour.
    sel = 1;
    do_reset();
    tname = "wrap_pos";
    cyc(1, 131071, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, WRAP_SUM, 0, 0);
    cyc(0, 0, 0, 1, 131070, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    tname = "wrap_neg";
    cyc(1, -131072, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, -131071, 0, 0);
    cyc(0, 0, 0, 1, WRAP_DIFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // LENGTH=4 gap at cnt=5: non-zero data with valid low must count as zero.
    sel = 2;
    do_reset();
    tname = "gap";
    cyc(1, 1, -1, 0, 0, 0, 0);
    cyc(1, 2, -2, 0, 0, 0, 0);
    cyc(1, 3, -3, 0, 0, 0, 0);
    cyc(1, 4, -4, 0, 0, 0, 0);
    cyc(1, 5, -5, 1, 6, -6, 0);
    cyc(0, 6, -6, 1, 2, -2, 1);
    cyc(1, 7, -7, 1, 10, -10, 0);
    cyc(1, 8, -8, 1, 12, -12, 0);
    cyc(0, 0, 0, 1, -4, 4, 0);
    cyc(0, 0, 0, 1, 2, -2, 0);
    cyc(0, 0, 0, 1, -4, 4, 0);
    cyc(0, 0, 0, 1, -4, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // LENGTH=4 sample arriving in flush cycle 1 is dropped and flagged.
    tname = "flush_intrude";
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 4, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 1, 6, 0, 0);
    cyc(1, 6, 0, 1, 8, 0, 0);
    cyc(1, 7, 0, 1, 10, 0, 0);
    cyc(1, 8, 0, 1, 12, 0, 0);
    cyc(0, 0, 0, 1, -4, 0, 0);
    cyc(1, 99, 0, 1, -4, 0, 1);
    cyc(0, 0, 0, 1, -4, 0, 0);
    cyc(0, 0, 0, 1, -4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdf_bf_stage.md
Name: sdf_bf_stage

Overview:
- Radix-2 single-delay-feedback (SDF) butterfly stage for the 32-point FFT pipeline. It sits directly upstream of the feedback shift register.
- It drives the delay line's input, consumes the delay line's output, and emits butterfly sums and differences in natural SDF order.
- One instance per FFT stage: LENGTH = 16, 8, 4, 2, 1. The external delay line has latency exactly LENGTH cycles and shifts every clock.

Parameters:
- LENGTH, 16, feedback delay depth and half-frame length. Must be a power of two, >= 1.
- CW, log2(2*LENGTH) (min 1), internal counter width. Derived; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input sample valid, one sample per cycle within a frame.
- in_r  input  18  input real part, two's complement.
- in_i  input  18  input imaginary part, two's complement.
- fb_in_r  input  18  delay line output, real.
- fb_in_i  input  18  delay line output, imaginary.
- fb_out_r  output  18  delay line input, real (combinational).
- fb_out_i  output  18  delay line input, imaginary (combinational).
- out_valid  output  1  output sample valid (registered).
- out_r  output  18  butterfly output, real (registered).
- out_i  output  18  butterfly output, imaginary (registered).
- frame_err  output  1  one-cycle pulse on protocol violation (registered).

Behaviour:
- Reset: synchronous on rising clk with rst_n=0, overriding all other activity, including mid-frame. Effects: state=IDLE, cnt=0, primed=0, out_r=out_i=0, out_valid=0, frame_err=0. fb_out_r/i are forced to 0 while rst_n=0.
- Counter cnt (CW bits) wraps 2*LENGTH-1 -> 0. Phase A: cnt < LENGTH. Phase B: cnt >= LENGTH.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - cnt=0, fb_out=0, out_valid=0.
  - in_valid=1 -> accept the sample as cnt=0, go to RUN.
- RUN, Phase A:
  - fb_out = in.
  - out <= fb_in (the differences from the previous frame).
  - out_valid <= primed.
- RUN, Phase B:
  - sum = fb_in + in, diff = fb_in - in, each computed at 19 bits and reduced to 18 bits.
  - out <= sum, fb_out = diff, out_valid <= 1.
  - primed set to 1 at the first Phase B cycle.
- cnt advances every RUN cycle.
- Missing sample in RUN: in_valid=0 with cnt != 0 -> the input is treated as 0, cnt still advances, frame_err pulses 1 on the next cycle.
- Frame end: at cnt wrap, i.e. the cycle where cnt would be 0:
  - in_valid=1 -> stay in RUN (back-to-back frames, no bubble).
  - in_valid=0 -> go to FLUSH, with cnt=0.
- FLUSH: runs for LENGTH cycles (cnt 0..LENGTH-1).
  - fb_out=0, out <= fb_in, out_valid <= 1.
  - After the cycle with cnt=LENGTH-1: go to IDLE and clear primed.
  - in_valid=1 during FLUSH -> the sample is dropped and frame_err pulses.
- Latency:
  - The first output (x[0]+x[LENGTH]) appears LENGTH+1 cycles after x[0] is accepted.
  - The frame occupies 2*LENGTH contiguous out_valid cycles: LENGTH sums, then LENGTH differences.
- Width rule: default is wrap-around. Bits [17:0] of the 19-bit result are kept; there is no scaling.
- LENGTH=1: Phase A and Phase B alternate every cycle; FLUSH lasts 1 cycle.

Optional Feature:
- Macro SDF_BF_SAT_EN.
- Defined: sum and diff saturate to the range [-131072, 131071] before driving out and fb_out.
- Undefined: two's-complement wrap-around (the 19-bit result truncated to bits [17:0]).
- Counter, state machine, and timing are identical in both builds.

Test Plan:
- Reset mid-frame: LENGTH=2, reset held 1 cycle after 3 samples -> next cycle out_valid=0, out_r=0, frame_err=0, state IDLE. A fresh frame then behaves as in the single-frame case.
- Single frame: LENGTH=2, real inputs 1,2,3,4 on cycles 0-3, imaginary parts 0, in_valid then low, delay line modelled as a 2-cycle register chain.
  - out_valid on cycles 3-6.
  - out_r sequence = 4, 6, -2, -2; out_i = 0.
  - out_valid=0 from cycle 7.
- Back-to-back frames: LENGTH=2, frames (1,2,3,4) then (10,20,30,40) with no gap.
  - Continuous outputs 4, 6, -2, -2, 40, 60, -20, -20.
  - frame_err never asserts.
- Wrap vs saturation: LENGTH=1, in_r = 131071 then 1.
  - Without macro: out_r = -131072, then diff 131070.
  - With SDF_BF_SAT_EN: out_r = 131071.
  - Separately, inputs -131072 then 1: diff = -131073, which wraps to 131071 without the macro and saturates to -131072 with it.
- Mid-frame gap: LENGTH=4, in_valid low at cnt=5 -> that sample is treated as 0, frame_err pulses for 1 cycle, and all outputs match a zero-substituted reference model.
- FLUSH intrusion: LENGTH=4, in_valid=1 at FLUSH cycle 1 -> the sample is dropped, frame_err pulses, FLUSH completes its 4 outputs, then IDLE.
